// File: rtl/cdb_arb_pkg.sv
// Shared types and helpers for the common-data-bus arbiter.
package cdb_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef logic [NUM_REQ-1:0] req_vec_t;
  typedef logic [SEL_W-1:0]   sel_t;

  function automatic req_vec_t onehot4(sel_t s);
    req_vec_t v;
    v    = '0;
    v[s] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational 4-way round-robin picker: first set bit of elig scanning
// upward from ptr with wrap-around.
module rr_pick4
  import cdb_arb_pkg::*;
(
  input  req_vec_t elig,
  input  sel_t     ptr,
  output logic     found,
  output sel_t     winner
);

  sel_t cand;

  // Scan from the farthest candidate back to ptr so the nearest eligible one is kept.
  always_comb begin
    found  = 1'b0;
    winner = ptr;
    cand   = ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = ptr + sel_t'(k);
      if (elig[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

endmodule

// File: rtl/cdb_bus_arbiter.sv
// Round-robin arbiter for the 4-source CDB: registered grant, NAND-mux select pair,
// stall/flush handling and per-requester starvation flags.
module cdb_bus_arbiter
  import cdb_arb_pkg::*;
#(
  parameter int PTR_RESET = 0,
  parameter int MAX_WAIT  = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic       stall,
  input  logic       flush,
  output logic [3:0] grant,
  output logic [1:0] select,
  output logic [1:0] invSelect,
  output logic       bus_valid,
  output logic [3:0] starve
);

  localparam int                WAIT_W   = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);
  localparam sel_t              PTR_INIT = sel_t'(PTR_RESET);

  sel_t     ptr;
  req_vec_t elig;
  logic     found;
  sel_t     winner;

  req_vec_t grant_nxt;
  sel_t     select_nxt;
  logic     bus_valid_nxt;
  sel_t     ptr_nxt;
  req_vec_t starve_nxt;

  // The unit holding the bus this cycle sits out the next arbitration.
  assign elig = req & ~grant;

  rr_pick4 u_pick (
    .elig   (elig),
    .ptr    (ptr),
    .found  (found),
    .winner (winner)
  );

  always_comb begin
    grant_nxt     = '0;
    select_nxt    = select;
    bus_valid_nxt = 1'b0;
    ptr_nxt       = ptr;
    if (!flush && !stall && found) begin
      grant_nxt     = onehot4(winner);
      select_nxt    = winner;
      bus_valid_nxt = 1'b1;
      ptr_nxt       = winner + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      grant     <= '0;
      select    <= 2'b00;
      invSelect <= 2'b11;
      bus_valid <= 1'b0;
      ptr       <= PTR_INIT;
      starve    <= '0;
    end else begin
      grant     <= grant_nxt;
      select    <= select_nxt;
      invSelect <= ~select_nxt;
      bus_valid <= bus_valid_nxt;
      ptr       <= ptr_nxt;
      starve    <= starve_nxt;
    end
  end

  // Per-requester wait counters, saturating at MAX_WAIT.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_wait
    logic [WAIT_W-1:0] cnt;
    logic [WAIT_W-1:0] cnt_nxt;

    always_comb begin
      cnt_nxt = cnt;
      if (flush || !req[i] || grant_nxt[i]) begin
        cnt_nxt = '0;
      end else if (cnt != WAIT_MAX) begin
        cnt_nxt = cnt + 1'b1;
      end
    end

    assign starve_nxt[i] = (cnt_nxt == WAIT_MAX);

    always_ff @(posedge clk) begin
      if (!reset) begin
        cnt <= '0;
      end else begin
        cnt <= cnt_nxt;
      end
    end
  end

endmodule

// File: tb/tb_cdb_bus_arbiter.sv
// Testbench for cdb_bus_arbiter: table of hand-computed vectors through a
// scoreboard queue, plus a continuous all-request rotation sequence.
module tb_cdb_bus_arbiter;

  logic       clk;
  logic       reset;
  logic [3:0] req;
  logic       stall;
  logic       flush;
  logic [3:0] grant;
  logic [1:0] select;
  logic [1:0] invSelect;
  logic       bus_valid;
  logic [3:0] starve;

  cdb_bus_arbiter #(
    .PTR_RESET (0),
    .MAX_WAIT  (3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .stall     (stall),
    .flush     (flush),
    .grant     (grant),
    .select    (select),
    .invSelect (invSelect),
    .bus_valid (bus_valid),
    .starve    (starve)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic [3:0] req;
    logic       stall;
    logic       flush;
    logic [3:0] g;
    logic [1:0] sel;
    logic       bv;
    logic [3:0] st;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   n_vec;
  int   n_cmp;
  int   miscompares;

  function automatic void add(input logic r, input logic [3:0] q, input logic s,
                              input logic f, input logic [3:0] g, input logic [1:0] se,
                              input logic b, input logic [3:0] st);
    vec_t v;
    v.rst_n = r; v.req = q; v.stall = s; v.flush = f;
    v.g = g; v.sel = se; v.bv = b; v.st = st;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input int idx, input logic [3:0] act,
                     input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at vector %0d: got %b expected %b", name, idx, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t       e;
    logic [1:0] inv_exp;
    n_vec = 0; n_cmp = 0; miscompares = 0;
    reset = 1'b0; req = '0; stall = 1'b0; flush = 1'b0;

    // reset, single request, reset overriding requests
    add(0, 4'b0000, 0, 0, 4'b0000, 2'b00, 0, 4'b0000);
    add(0, 4'b1111, 0, 0, 4'b0000, 2'b00, 0, 4'b0000);
    add(1, 4'b0100, 0, 0, 4'b0100, 2'b10, 1, 4'b0000);
    add(1, 4'b0000, 0, 0, 4'b0000, 2'b10, 0, 4'b0000);
    // all four request, each drops after its grant; unit 3 reaches starve
    add(0, 4'b0000, 0, 0, 4'b0000, 2'b00, 0, 4'b0000);
    add(1, 4'b1111, 0, 0, 4'b0001, 2'b00, 1, 4'b0000);
    add(1, 4'b1110, 0, 0, 4'b0010, 2'b01, 1, 4'b0000);
    add(1, 4'b1100, 0, 0, 4'b0100, 2'b10, 1, 4'b1000);
    add(1, 4'b1000, 0, 0, 4'b1000, 2'b11, 1, 4'b0000);
    add(1, 4'b0000, 0, 0, 4'b0000, 2'b11, 0, 4'b0000);
    // ptr at 3 after granting unit 2: unit 3 beats unit 0, then unit 0
    add(1, 4'b0100, 0, 0, 4'b0100, 2'b10, 1, 4'b0000);
    add(1, 4'b1001, 0, 0, 4'b1000, 2'b11, 1, 4'b0000);
    add(1, 4'b0001, 0, 0, 4'b0001, 2'b00, 1, 4'b0000);
    add(1, 4'b0000, 0, 0, 4'b0000, 2'b00, 0, 4'b0000);
    // stall for 5 cycles, starve saturates, grant after release
    add(1, 4'b0010, 1, 0, 4'b0000, 2'b00, 0, 4'b0000);
    add(1, 4'b0010, 1, 0, 4'b0000, 2'b00, 0, 4'b0000);
    add(1, 4'b0010, 1, 0, 4'b0000, 2'b00, 0, 4'b0010);
    add(1, 4'b0010, 1, 0, 4'b0000, 2'b00, 0, 4'b0010);
    add(1, 4'b0010, 1, 0, 4'b0000, 2'b00, 0, 4'b0010);
    add(1, 4'b0010, 0, 0, 4'b0010, 2'b01, 1, 4'b0000);
    add(1, 4'b0000, 0, 0, 4'b0000, 2'b01, 0, 4'b0000);
    // starve then flush (with and without stall)
    add(1, 4'b0010, 1, 0, 4'b0000, 2'b01, 0, 4'b0000);
    add(1, 4'b0010, 1, 0, 4'b0000, 2'b01, 0, 4'b0000);
    add(1, 4'b0010, 1, 0, 4'b0000, 2'b01, 0, 4'b0010);
    add(1, 4'b0010, 1, 0, 4'b0000, 2'b01, 0, 4'b0010);
    add(1, 4'b0010, 1, 1, 4'b0000, 2'b01, 0, 4'b0000);
    add(1, 4'b0010, 0, 1, 4'b0000, 2'b01, 0, 4'b0000);
    add(1, 4'b0010, 0, 0, 4'b0010, 2'b01, 1, 4'b0000);
    add(1, 4'b0000, 0, 0, 4'b0000, 2'b01, 0, 4'b0000);
    // reset while unit 3 holds the bus, re-arbitration from PTR_RESET
    add(1, 4'b1010, 0, 0, 4'b1000, 2'b11, 1, 4'b0000);
    add(0, 4'b1010, 0, 0, 4'b0000, 2'b00, 0, 4'b0000);
    add(1, 4'b1010, 0, 0, 4'b0010, 2'b01, 1, 4'b0000);
    add(1, 4'b1000, 0, 0, 4'b1000, 2'b11, 1, 4'b0000);
    add(1, 4'b0000, 0, 0, 4'b0000, 2'b11, 0, 4'b0000);

    foreach (vecs[i]) begin
      @(negedge clk);
      reset = vecs[i].rst_n; req = vecs[i].req;
      stall = vecs[i].stall; flush = vecs[i].flush;
      sb.push_back(vecs[i]);
      @(posedge clk);
      #1;
      e       = sb.pop_front();
      inv_exp = ~e.sel;
      n_vec++;
      chk("grant",     i, grant,              e.g);
      chk("select",    i, {2'b00, select},    {2'b00, e.sel});
      chk("invSelect", i, {2'b00, invSelect}, {2'b00, inv_exp});
      chk("bus_valid", i, {3'b000, bus_valid}, {3'b000, e.bv});
      chk("starve",    i, starve,             e.st);
    end

    // Continuous all-request rotation: units never drop req, grants still rotate.
    @(negedge clk);
    reset = 1'b0; req = 4'b1111; stall = 1'b0; flush = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 8; k++) begin
      logic [3:0] g_exp;
      logic [1:0] s_exp;
      s_exp = 2'(k % 4);
      g_exp = 4'b0001 << s_exp;
      @(posedge clk);
      #1;
      n_vec++;
      chk("rot_grant",  100 + k, grant,              g_exp);
      chk("rot_select", 100 + k, {2'b00, select},    {2'b00, s_exp});
      chk("rot_inv",    100 + k, {2'b00, invSelect}, {2'b00, ~s_exp});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, miscompares);
    $finish;
  end

endmodule

// File: doc/cdb_bus_arbiter.md
Name: cdb_bus_arbiter

Overview:
Round-robin arbiter for the 4-source common data bus (CDB) of the out-of-order core. Four functional units request the bus. Each cycle the arbiter grants at most one of them and drives the select/invSelect pair of the shared 4:1 NAND bus-mux bit-slices, so the granted unit's result reaches the CDB. It also supports downstream stall, pipeline flush and per-requester starvation flags.

Parameters:
PTR_RESET, 0, requester index holding highest priority after reset (0..3)
MAX_WAIT, 15, cycles a requester may wait with req high before its starve flag sets (1..255)

Ports:
clk  in  1  system clock, all state updates on posedge
reset  in  1  synchronous, active-low reset; sampled at posedge clk
req  in  4  req[i]=1: unit i has a result ready for the bus
stall  in  1  CDB consumers cannot accept; no grant issued
flush  in  1  mispredict flush; suppress grant, clear wait counters
grant  out  4  one-hot (or zero) registered grant; unit i owns bus this cycle
select  out  2  registered mux select = index of granted unit
invSelect  out  2  registered, always bitwise ~select
bus_valid  out  1  registered; 1 exactly when grant != 0
starve  out  4  starve[i]=1 while unit i's wait counter is at MAX_WAIT

Behaviour:
- Reset (reset==0 at posedge): grant=0, bus_valid=0, select=2'b00, invSelect=2'b11, ptr=PTR_RESET, all wait counters=0, starve=0. Reset overrides every other input. Reset mid-transfer drops the grant on the next edge; the requester keeps req high and is re-arbitrated.
- Invariant: invSelect==~select in every cycle, including reset. The mux NAND inputs never see an illegal pair.
- Eligible set: elig = req & ~grant (registered grant). The unit granted this cycle is never re-granted on the next edge, even if req stays high. Back-to-back grants to one unit need another unit idle and a one-cycle gap.
- Priority: candidates are scanned in order ptr, ptr+1, ptr+2, ptr+3 (mod 4). The first eligible candidate wins.
- Next-state per posedge, in priority order:
  - flush=1 (wins over stall): grant=0, bus_valid=0, select/invSelect hold, ptr holds, all wait counters cleared.
  - stall=1: grant=0, bus_valid=0, select/invSelect hold, ptr holds. Counters of requesting units keep counting.
  - elig!=0: grant=onehot(w), select=w, invSelect=~w, bus_valid=1, ptr=(w+1) mod 4 (3 wraps to 0).
  - elig==0: grant=0, bus_valid=0, select/invSelect hold, ptr holds.
- Latency: req rising at cycle t gives a grant no earlier than cycle t+1. Worst case with all four requesting continuously: grant within 4 non-stalled cycles.
- Requester contract: hold req and result data stable until grant[i] is seen. Data must be valid during the grant cycle. The cycle after the grant, either deassert req or present the next result.
- Wait counter per unit, width $clog2(MAX_WAIT+1):
  - clears when req[i]=0, when unit i is granted on this edge, or on flush.
  - otherwise increments, saturating at MAX_WAIT.
  - starve[i] is registered and equals (wait[i]==MAX_WAIT).
- Arbitration is combinational from registered state plus inputs. All outputs are registered; no combinational input-to-output path.

Decomposition:
- Package cdb_arb_pkg: NUM_REQ=4, SEL_W=2, typedef logic [3:0] req_vec_t, typedef logic [1:0] sel_t, function onehot4(sel_t).
- Sub-module rr_pick4: combinational; inputs elig and ptr; outputs found and winner index. Instantiated once.
- Wait counters live in the top module as a 4-entry generate loop.

Test Plan:
- Reset with PTR_RESET=0, then req=4'b0100 held 1 cycle -> next cycle grant=4'b0100, select=2'b10, invSelect=2'b01, bus_valid=1; following cycle grant=0.
- req=4'b1111 held, requesters deassert after grant -> grants 0001,0010,0100,1000 on consecutive cycles; select 0,1,2,3; ptr wraps to 0.
- ptr=3 (after granting unit 2), req=4'b1001 -> unit 3 granted first (select=2'b11), then unit 0 next cycle.
- req=4'b0010 with stall=1 for 5 cycles -> grant=0 and select held throughout; grant=4'b0010 the cycle after stall drops.
- MAX_WAIT=3, req[1] held, stall=1 -> starve[1]=1 after 3 cycles and stays 1; flush pulse clears starve[1] the next cycle; stall and flush together behave as flush.
- reset driven low while grant=4'b1000 -> next edge grant=0, select=00, invSelect=11, bus_valid=0; after release, the pending req is re-granted from PTR_RESET order.
